// File: rtl/hyper_lsab_cr_if.sv
// hyper_lsab_cr_if: producer/consumer bus of the four-section LSAB; LSAB_ERR_FLAGS_EN adds sticky error flags
interface hyper_lsab_cr_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
);
  logic                          WRITE;
  logic [1:0]                    WRITE_SECTION;
  logic [WIDTH-1:0]              WRITE_DATA;
  logic [3:0]                    LSAB_FULL;
  logic [3:0]                    FLUSH;
  logic                          LSAB_READ;
  logic [1:0]                    LSAB_SECTION;
  logic [WIDTH-1:0]              READ_DATA;
  logic                          LSAB_0_STOP;
  logic                          LSAB_1_STOP;
  logic                          LSAB_2_STOP;
  logic                          LSAB_3_STOP;
  logic [4*(DEPTH_LOG2+1)-1:0]   FILL_COUNT;
`ifdef LSAB_ERR_FLAGS_EN
  logic [3:0]                    LSAB_OVERFLOW;
  logic [3:0]                    LSAB_UNDERFLOW;
`endif
  modport master (
    output WRITE, WRITE_SECTION, WRITE_DATA, FLUSH, LSAB_READ, LSAB_SECTION,
`ifdef LSAB_ERR_FLAGS_EN
    input  LSAB_OVERFLOW, LSAB_UNDERFLOW,
`endif
    input  LSAB_FULL, READ_DATA, LSAB_0_STOP, LSAB_1_STOP, LSAB_2_STOP, LSAB_3_STOP, FILL_COUNT
  );
  modport slave (
    input  WRITE, WRITE_SECTION, WRITE_DATA, FLUSH, LSAB_READ, LSAB_SECTION,
`ifdef LSAB_ERR_FLAGS_EN
    output LSAB_OVERFLOW, LSAB_UNDERFLOW,
`endif
    output LSAB_FULL, READ_DATA, LSAB_0_STOP, LSAB_1_STOP, LSAB_2_STOP, LSAB_3_STOP, FILL_COUNT
  );
endinterface

// File: rtl/hyper_lsab_cr.sv
// hyper_lsab_cr: four-section circular load/store assist buffer on one shared memory; LSAB_ERR_FLAGS_EN adds sticky overflow/underflow flags
module hyper_lsab_cr #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic             CLK,
  input  logic             RST,
  hyper_lsab_cr_if.slave   bus
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int SZ = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] FULL_CNT = CW'(SZ);
  logic [DEPTH_LOG2-1:0] r_wr_ptr [4];
  logic [DEPTH_LOG2-1:0] r_rd_ptr [4];
  logic [CW-1:0]         r_count  [4];
  logic [WIDTH-1:0]      r_mem    [4*SZ];
  logic [WIDTH-1:0]      r_read_data;
  logic [3:0]            w_full, w_empty, w_wr_hit, w_rd_hit;
  logic                  w_wr_ok, w_rd_ok;
  logic [4*CW-1:0]       w_fill;
  // a flushed section rejects both accesses in the same cycle
  always_comb begin
    w_fill = '0;
    for (int n = 0; n < 4; n++) begin
      w_full[n]             = r_count[n] == FULL_CNT;
      w_empty[n]            = r_count[n] == '0;
      w_fill[n*CW +: CW]    = r_count[n];
    end
    w_wr_ok  = bus.WRITE && !w_full[bus.WRITE_SECTION] && !bus.FLUSH[bus.WRITE_SECTION];
    w_rd_ok  = bus.LSAB_READ && !w_empty[bus.LSAB_SECTION] && !bus.FLUSH[bus.LSAB_SECTION];
    w_wr_hit = w_wr_ok ? 4'b0001 << bus.WRITE_SECTION : 4'b0000;
    w_rd_hit = w_rd_ok ? 4'b0001 << bus.LSAB_SECTION : 4'b0000;
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      for (int n = 0; n < 4; n++) begin
        r_wr_ptr[n] <= '0;
        r_rd_ptr[n] <= '0;
        r_count[n]  <= '0;
      end
      r_read_data <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (bus.FLUSH[n]) begin
          r_wr_ptr[n] <= '0;
          r_rd_ptr[n] <= '0;
          r_count[n]  <= '0;
        end else begin
          r_wr_ptr[n] <= r_wr_ptr[n] + DEPTH_LOG2'(w_wr_hit[n]);
          r_rd_ptr[n] <= r_rd_ptr[n] + DEPTH_LOG2'(w_rd_hit[n]);
          r_count[n]  <= r_count[n] + CW'(w_wr_hit[n]) - CW'(w_rd_hit[n]);
        end
      end
      if (w_rd_ok) r_read_data <= r_mem[{bus.LSAB_SECTION, r_rd_ptr[bus.LSAB_SECTION]}];
    end
  always_ff @(posedge CLK)
    if (w_wr_ok) r_mem[{bus.WRITE_SECTION, r_wr_ptr[bus.WRITE_SECTION]}] <= bus.WRITE_DATA;
`ifdef LSAB_ERR_FLAGS_EN
  logic [3:0] r_ovf, r_udf;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        r_ovf[n] <= bus.FLUSH[n] ? 1'b0 : r_ovf[n] | (bus.WRITE && bus.WRITE_SECTION == 2'(n) && w_full[n]);
        r_udf[n] <= bus.FLUSH[n] ? 1'b0 : r_udf[n] | (bus.LSAB_READ && bus.LSAB_SECTION == 2'(n) && w_empty[n]);
      end
    end
  assign bus.LSAB_OVERFLOW  = r_ovf;
  assign bus.LSAB_UNDERFLOW = r_udf;
`endif
  assign bus.LSAB_FULL   = w_full;
  assign bus.READ_DATA   = r_read_data;
  assign bus.LSAB_0_STOP = w_empty[0];
  assign bus.LSAB_1_STOP = w_empty[1];
  assign bus.LSAB_2_STOP = w_empty[2];
  assign bus.LSAB_3_STOP = w_empty[3];
  assign bus.FILL_COUNT  = w_fill;
endmodule
